// File: rtl/issue_stage.sv
// Decode/issue: 64x32 regfile (r32-r63 FP), pending-write scoreboard, registered op bundle to execute.
// Latency 1 cycle inst -> bundle; busy unit or pending operand stalls (inst_ready=0, bubble issued).
// Branch squash consumes without issuing; ISSUE_WB_BYPASS_EN adds same-cycle writeback forwarding.
module issue_stage #(
    parameter int NREG = 64,
    parameter int PCW  = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic [PCW-1:0]  inst_pc,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [5:0]      alu_addr,
    input  logic [31:0]     alu_dd_val,
    input  logic [5:0]      fpu_addr,
    input  logic [31:0]     fpu_dd_val,
    input  logic [6:0]      is_busy,
    input  logic            b_is_hazard,
    input  logic [PCW-1:0]  b_addr,
    output logic [PCW-1:0]  pc,
    output logic [5:0]      ope,
    output logic [31:0]     ds_val,
    output logic [31:0]     dt_val,
    output logic [5:0]      dd,
    output logic [15:0]     imm,
    output logic [4:0]      opr,
    output logic [3:0]      ctrl,
    output logic            redirect_valid,
    output logic [PCW-1:0]  redirect_pc
);
    localparam logic [5:0] OP_LUI  = 6'b000011;
    localparam logic [5:0] OP_ADD  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SUB  = 6'b001100;
    localparam logic [5:0] OP_SLL  = 6'b010000;
    localparam logic [5:0] OP_SLLI = 6'b010100;
    localparam logic [5:0] OP_SRL  = 6'b011000;
    localparam logic [5:0] OP_SRLI = 6'b011100;
    localparam logic [5:0] OP_SRA  = 6'b100000;
    localparam logic [5:0] OP_SRAI = 6'b100100;
    localparam logic [5:0] OP_JAL  = 6'b000110;
    localparam logic [5:0] OP_JALR = 6'b001110;

    logic [31:0]     regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] wb_clr;
    logic [NREG-1:0] pend_vis;
    logic [NREG-1:0] pend_chk;
    logic [NREG-1:0] set_vec;
    logic [5:0]      op_f;
    logic            fp_op;
    logic [5:0]      ds_a;
    logic [5:0]      dt_a;
    logic [5:0]      dd_a;
    logic [31:0]     ds_rd;
    logic [31:0]     dt_rd;
    logic            stall;
    logic            issue;

    assign op_f  = inst[31:26];
    assign fp_op = (op_f[1:0] == 2'b01);

    always_comb begin
        ds_a = {fp_op, inst[20:16]};
        dt_a = {fp_op, inst[15:11]};
        dd_a = 6'd0;
        if (fp_op) begin
            dd_a = {1'b1, inst[25:21]};
        end else begin
            case (op_f)
                OP_LUI, OP_ADD, OP_ADDI, OP_SUB, OP_SLL, OP_SLLI,
                OP_SRL, OP_SRLI, OP_SRA, OP_SRAI: dd_a = {1'b0, inst[25:21]};
                OP_JAL, OP_JALR:                  dd_a = 6'd31;
                default:                          dd_a = 6'd0;
            endcase
        end
    end

    always_comb begin
        wb_clr = '0;
        if (alu_addr != 6'd0) wb_clr[alu_addr] = 1'b1;
        if (fpu_addr != 6'd0) wb_clr[fpu_addr] = 1'b1;
    end

    // Operand read; with bypass the FPU result shadows the ALU result on an address clash.
    always_comb begin
        ds_rd = regs[ds_a];
        dt_rd = regs[dt_a];
`ifdef ISSUE_WB_BYPASS_EN
        if (alu_addr != 6'd0 && alu_addr == ds_a) ds_rd = alu_dd_val;
        if (fpu_addr != 6'd0 && fpu_addr == ds_a) ds_rd = fpu_dd_val;
        if (alu_addr != 6'd0 && alu_addr == dt_a) dt_rd = alu_dd_val;
        if (fpu_addr != 6'd0 && fpu_addr == dt_a) dt_rd = fpu_dd_val;
        pend_vis = pending & ~wb_clr;
`else
        pend_vis = pending;
`endif
    end

    assign pend_chk   = {pend_vis[NREG-1:1], 1'b0};
    assign stall      = inst_valid & ((|is_busy) | pend_chk[ds_a] | pend_chk[dt_a] | pend_chk[dd_a]);
    assign issue      = inst_valid & ~b_is_hazard & ~stall;
    assign inst_ready = ~rst & inst_valid & (b_is_hazard | ~stall);

    assign redirect_valid = b_is_hazard;
    assign redirect_pc    = b_addr;

    always_comb begin
        set_vec = '0;
        if (issue && dd_a != 6'd0) set_vec[dd_a] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wb_clr) | set_vec;
        end
    end

    // Two writes to the same register in one cycle: the later FPU assignment wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (alu_addr != 6'd0) regs[alu_addr] <= alu_dd_val;
            if (fpu_addr != 6'd0) regs[fpu_addr] <= fpu_dd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            pc     <= '0;
            ope    <= '0;
            ds_val <= '0;
            dt_val <= '0;
            dd     <= '0;
            imm    <= '0;
            opr    <= '0;
            ctrl   <= '0;
        end else begin
            pc     <= inst_pc;
            ope    <= op_f;
            ds_val <= ds_rd;
            dt_val <= dt_rd;
            dd     <= dd_a;
            imm    <= inst[15:0];
            opr    <= inst[15:11];
            ctrl   <= fp_op ? inst[3:0] : 4'd0;
        end
    end
endmodule
